// File: rtl/majority_voter_sync_if.sv
// rtl/majority_voter_sync_if.sv - channel inputs and vote outputs of majority_voter_sync
interface majority_voter_sync_if #(
    parameter int N = 3
) ();
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  IN;
    logic          CLEAR_FAULT;
    logic          VOTE;
    logic [CW-1:0] VOTE_COUNT;
    logic [N-1:0]  DEBOUNCED;
    logic [N-1:0]  DISAGREE;
    logic [N-1:0]  FAULT_MASK;

    modport master (
        output IN, CLEAR_FAULT,
        input  VOTE, VOTE_COUNT, DEBOUNCED, DISAGREE, FAULT_MASK
    );

    modport slave (
        input  IN, CLEAR_FAULT,
        output VOTE, VOTE_COUNT, DEBOUNCED, DISAGREE, FAULT_MASK
    );
endinterface

// File: rtl/majority_voter_sync.sv
// rtl/majority_voter_sync.sv - synchronised, debounced N-channel threshold voter
// Optional sticky disagreement latch enabled by defining VOTER_FAULT_LATCH_EN.
module majority_voter_sync #(
    parameter int N               = 3,
    parameter int THRESHOLD       = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    majority_voter_sync_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (THRESHOLD < 1 || THRESHOLD > N) begin : g_bad_threshold
        $error("majority_voter_sync: THRESHOLD must be within 1..N");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("majority_voter_sync: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N-1:0]  s1_q;
    logic [N-1:0]  s2_q;
    logic [DW-1:0] cnt_q [N];
    logic [DW-1:0] cnt_d [N];
    logic [N-1:0]  deb_q;
    logic [N-1:0]  deb_d;
    logic          vote_q;
    logic          vote_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [N-1:0]  dis_q;
    logic [N-1:0]  dis_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end else begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end
        end
    end

    // Vote stage works from the registered debounced vector, so channels that
    // qualify on the same edge are always counted together.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < N; i++) begin
            count_d = count_d + CW'(deb_q[i]);
        end
        vote_d = (count_d >= CW'(THRESHOLD));
        dis_d  = deb_q ^ {N{vote_d}};
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            vote_q  <= 1'b0;
            count_q <= '0;
            dis_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= bus.IN;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            vote_q  <= vote_d;
            count_q <= count_d;
            dis_q   <= dis_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef VOTER_FAULT_LATCH_EN
    logic [N-1:0] fault_q;
    logic [N-1:0] fault_d;

    // A fresh disagreement outranks a simultaneous clear.
    always_comb begin
        fault_d = (fault_q & ~{N{bus.CLEAR_FAULT}}) | dis_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            fault_q <= '0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.FAULT_MASK = fault_q;
`else
    logic unused_clear_fault;
    assign unused_clear_fault = bus.CLEAR_FAULT;
    assign bus.FAULT_MASK     = '0;
`endif

    assign bus.VOTE       = vote_q;
    assign bus.VOTE_COUNT = count_q;
    assign bus.DEBOUNCED  = deb_q;
    assign bus.DISAGREE   = dis_q;
endmodule
